// File: rtl/accum_batch_ctrl.sv
// Batch accumulate sequencer: accepts a programmed number of operands over a
// valid/ready stream, sums them into an N-bit accumulator, tracks sticky
// carry / signed overflow, and pulses done with the final result.

// N-bit ripple-carry adder built from a full-adder chain.
module ripple_carry_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

module accum_batch_ctrl #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     sum,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] ops_left
);

  localparam int unsigned MSB = N - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [N-1:0]     add_s;
  logic             add_cout;
  logic             add_ovf_c;

  // Single adder: accumulator plus incoming operand.
  ripple_carry_adder #(.N(N)) u_adder (
    .a    (sum_q),
    .b    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

  // True two's-complement overflow: like-signed operands, result sign differs.
  assign add_ovf_c = (sum_q[MSB] == in_data[MSB]) && (add_s[MSB] != sum_q[MSB]);

  // State and datapath registers; aclr aborts any batch immediately.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ops_q   <= ops_d;
    end
  end

  // Next-state and datapath update; everything holds unless a case acts.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ops_d   = ops_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sum_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          ops_d   = count;
          state_d = (count != '0) ? S_ACCUM : S_DONE;
        end
      end

      S_ACCUM: begin
        // in_ready is high throughout ACCUM, so valid alone marks an accept.
        if (in_valid) begin
          sum_d   = add_s;
          carry_d = carry_q | add_cout;
          ovf_d   = ovf_q | add_ovf_c;
          ops_d   = ops_q - CNT_W'(1);
          if (ops_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status decode straight from the state register.
  assign in_ready = (state_q == S_ACCUM);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign ops_left = ops_q;

endmodule

// File: tb/tb_accum_batch_ctrl.sv
// Directed bench for accum_batch_ctrl with hand-computed expected values.
`timescale 1ns/1ps
module tb_accum_batch_ctrl;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             aclr;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [N-1:0]     sum;
  logic             carry;
  logic             overflow;
  logic [CNT_W-1:0] ops_left;

  int n_vec;
  int n_err;
  int n_done;

  accum_batch_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .start    (start),
    .count    (count),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow),
    .ops_left (ops_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses away from the active edge.
  always @(negedge clk) begin
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full result/status snapshot.
  task automatic chk_all(input string tag, input logic [7:0] e_sum, input logic e_c,
                         input logic e_v, input logic [3:0] e_ops, input logic e_rdy,
                         input logic e_busy, input logic e_done);
    chk({tag, ".sum"},      32'(sum),      32'(e_sum));
    chk({tag, ".carry"},    32'(carry),    32'(e_c));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_v));
    chk({tag, ".ops_left"}, 32'(ops_left), 32'(e_ops));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, ".busy"},     32'(busy),     32'(e_busy));
    chk({tag, ".done"},     32'(done),     32'(e_done));
  endtask

  task automatic do_start(input logic [3:0] cnt);
    start = 1'b1;
    count = cnt;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_done = 0;
    aclr = 1'b0; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;
    #1;
    chk_all("reset", 8'h00, 0, 0, 4'd0, 0, 0, 0);
    #12 aclr = 1'b1;
    step();
    chk_all("idle", 8'h00, 0, 0, 4'd0, 0, 0, 0);

    // Batch 10+20+30 back-to-back.
    do_start(4'd3);
    chk_all("b1.start", 8'h00, 0, 0, 4'd3, 1, 1, 0);
    send(8'd10);
    chk_all("b1.op1", 8'd10, 0, 0, 4'd2, 1, 1, 0);
    send(8'd20);
    chk_all("b1.op2", 8'd30, 0, 0, 4'd1, 1, 1, 0);
    send(8'd30);
    chk_all("b1.done", 8'h3C, 0, 0, 4'd0, 0, 1, 1);
    step();
    chk_all("b1.idle", 8'h3C, 0, 0, 4'd0, 0, 0, 0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #3 aclr = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 0, 0, 4'd0, 0, 0, 0);
    #2 aclr = 1'b1;
    step();

    // Unsigned wrap: 200+100 = 300 -> 44, carry, no signed overflow.
    do_start(4'd2);
    send(8'd200);
    chk_all("b2.op1", 8'd200, 0, 0, 4'd1, 1, 1, 0);
    send(8'd100);
    chk_all("b2.done", 8'h2C, 1, 0, 4'd0, 0, 1, 1);
    step();

    // Signed overflow: 0x70+0x20 = 0x90.
    do_start(4'd2);
    chk_all("b3.start", 8'h00, 0, 0, 4'd2, 1, 1, 0);
    send(8'h70);
    send(8'h20);
    chk_all("b3.done", 8'h90, 0, 1, 4'd0, 0, 1, 1);
    step();

    // Flags cleared by the next start.
    do_start(4'd1);
    chk_all("b4.start", 8'h00, 0, 0, 4'd1, 1, 1, 0);
    send(8'h05);
    chk_all("b4.done", 8'h05, 0, 0, 4'd0, 0, 1, 1);
    step();

    // Stall four cycles between operands; start pulse in ACCUM is ignored.
    do_start(4'd2);
    send(8'h11);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1;
        count = 4'd7;
      end
      step();
      start = 1'b0;
      chk_all($sformatf("stall%0d", i), 8'h11, 0, 0, 4'd1, 1, 1, 0);
    end
    send(8'h22);
    chk_all("stall.done", 8'h33, 0, 0, 4'd0, 0, 1, 1);
    step();

    // Operands offered in IDLE are ignored.
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("idle_valid%0d", i), 8'h33, 0, 0, 4'd0, 0, 0, 0);
    end

    // count=0: straight to DONE, nothing accepted even with valid held high.
    in_data = 8'h07;
    do_start(4'd0);
    chk_all("zero.done", 8'h00, 0, 0, 4'd0, 0, 1, 1);
    step();
    chk_all("zero.idle", 8'h00, 0, 0, 4'd0, 0, 0, 0);
    in_valid = 1'b0;

    // Reset mid-batch aborts without done.
    do_start(4'd4);
    send(8'd1);
    send(8'd2);
    chk_all("abort.mid", 8'd3, 0, 0, 4'd2, 1, 1, 0);
    #2 aclr = 1'b0;
    #1;
    chk_all("abort.rst", 8'h00, 0, 0, 4'd0, 0, 0, 0);
    step();
    step();
    chk_all("abort.hold", 8'h00, 0, 0, 4'd0, 0, 0, 0);
    #3 aclr = 1'b1;
    step();
    chk_all("abort.idle", 8'h00, 0, 0, 4'd0, 0, 0, 0);

    // A fresh batch completes normally afterwards.
    do_start(4'd1);
    send(8'h09);
    chk_all("after.done", 8'h09, 0, 0, 4'd0, 0, 1, 1);
    step();
    chk_all("after.idle", 8'h09, 0, 0, 4'd0, 0, 0, 0);

    // Seven completed batches, each with exactly one done pulse.
    step();
    chk("done_pulses", 32'(n_done), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/accum_batch_ctrl.md
Name: accum_batch_ctrl

Overview:
- Sequencer for the N-bit accumulate datapath (ripple-carry adder plus accumulator register).
- On a start command it accepts a programmed number of operands over a valid/ready stream and adds each into the accumulator.
- It tracks sticky unsigned carry and signed overflow, then pulses done with the final result.
- It sits between a switch/key front end or a producer FSM and the result display/LED logic.

Parameters:
- N, 8, operand and accumulator width in bits.
- CNT_W, 4, width of the operand-count field; at most 2^CNT_W-1 operands per batch.

Ports:
- clk  input  1  system clock, rising edge.
- aclr  input  1  asynchronous active-low reset.
- start  input  1  batch start request, sampled only in IDLE.
- count  input  CNT_W  number of operands in the batch, sampled with start.
- in_valid  input  1  operand valid.
- in_data  input  N  operand, two's complement or unsigned.
- in_ready  output  1  controller accepts an operand this cycle.
- busy  output  1  high in ACCUM and DONE.
- done  output  1  one-cycle completion pulse.
- sum  output  N  accumulator value.
- carry  output  1  sticky: any addition in the batch produced an adder carry-out.
- overflow  output  1  sticky: any addition in the batch produced signed overflow.
- ops_left  output  CNT_W  operands still to be accepted.

Behaviour:
- Reset: aclr low immediately forces state=IDLE and sum, carry, overflow, ops_left, done, in_ready, busy all to 0, regardless of clk. Reset mid-batch aborts the batch with no done pulse.
- States:
  - IDLE: in_ready=0, busy=0.
    - start=1 and count!=0: clear sum/carry/overflow, load ops_left=count, go to ACCUM.
    - start=1 and count=0: clear sum/carry/overflow, ops_left=0, go to DONE.
    - start=0: hold all outputs; the previous result stays visible.
  - ACCUM: in_ready=1, busy=1.
    - On an accept edge (in_valid=1 and in_ready=1): sum <= sum+in_data mod 2^N; carry |= cout; overflow |= (sum[N-1]==in_data[N-1]) and (new_sum[N-1]!=sum[N-1]); ops_left decrements.
    - Accept with ops_left=1: go to DONE.
    - in_valid=0: hold everything, with no timeout.
  - DONE: in_ready=0, busy=1, done=1 for exactly one cycle, then IDLE unconditionally.
- Addition uses one N-bit ripple_carry_adder with cin=0. The adder inputs are the accumulator register and in_data.
- Flag rules:
  - carry and overflow are sticky across the batch and cleared only by start or reset.
  - overflow is true two's-complement overflow, not cout^msb.
- Latency:
  - The first operand can be accepted in the cycle after the start edge.
  - One operand is accepted per cycle at most; back-to-back accepts are legal.
  - done rises in the cycle after the final accept edge, with final sum/flags valid that same cycle and held afterwards.
- start while busy is ignored; count is not resampled.
- in_valid while not in ACCUM is ignored; sum is unchanged.
- sum/carry/overflow are registered outputs. in_ready, busy and done decode from state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: assert aclr low mid-cycle -> all outputs 0 asynchronously. Release, then start with count=3 and operands 10, 20, 30 back-to-back -> done one cycle after the 3rd accept, sum=60 (0x3C), carry=0, overflow=0, ops_left 3→2→1→0.
- Unsigned wrap, N=8: count=2, operands 200, 100 -> sum=44 (0x2C), carry=1, overflow=0.
- Signed overflow: count=2, operands 0x70, 0x20 -> sum=0x90, overflow=1, carry=0. Next batch count=1, operand 0x05 -> flags cleared, sum=0x05, overflow=0.
- Stall and ignored inputs:
  - count=2; in_valid low 4 cycles between operands -> no progress and in_ready stays high; done only after the 2nd accept.
  - start pulsed during ACCUM -> no effect.
  - in_valid in IDLE -> sum unchanged.
- count=0 start -> DONE next cycle, done pulse with sum=0, no operand accepted (in_ready never high).
- Reset mid-batch: count=4, after 2 accepts pull aclr low -> IDLE, sum=0, no done. After release, a new batch completes normally.
